trigger_capture_seq: RTL

Sequencer for the trigger-capture datapath: arms on command, waits for a rising edge on `trig`, then captures a programmable burst of consecutive `din` samples into an internal buffer. It streams the burst out over a valid/ready interface. It sits between the control/register logic and the downstream consumer and replaces free-running capture with a one-shot, length-controlled capture.

---
 rtl/trigger_capture_pkg.sv | 16 +
 rtl/capture_buffer.sv | 29 ++
 rtl/trigger_capture_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/trigger_capture_pkg.sv
// Shared types and defaults for the trigger-capture sequencer.
// State encoding plus default sample, depth and timeout widths.
package trigger_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT
    } cap_state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_TMO_W = 16;

endpackage

// File: rtl/capture_buffer.sv
// Burst sample store: DEPTH x DW registers, no reset.
// One synchronous write port, one asynchronous read port.
module capture_buffer
    import trigger_capture_pkg::*;
#(
    parameter int  DW    = DEF_DW,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Sample write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trigger_capture_seq.sv
// One-shot trigger capture sequencer: arm, wait for trig rise, capture, stream.
// Optional ARMED timeout built when TRIG_CAPTURE_TIMEOUT_EN is defined.
module trigger_capture_seq
    import trigger_capture_pkg::*;
#(
    parameter int  DW    = DEF_DW,
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  TMO_W = DEF_TMO_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic [AW:0]      cap_len,
    input  logic [TMO_W-1:0] timeout_cycles,
    input  logic             trig,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             armed,
    output logic             busy,
    output logic             timeout
);

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] LMAX = (AW+1)'(DEPTH);

    cap_state_t    state, state_d;
    logic          trig_q, trig_edge;
    logic [AW:0]   len, len_d;
    logic [AW:0]   wr, wr_d;
    logic [AW:0]   rd, rd_d;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_rdata;
    logic          last_beat;

`ifdef TRIG_CAPTURE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_lat, tmo_lat_d;
    logic [TMO_W-1:0] tcnt, tcnt_d;
    logic             tpulse, tpulse_d;
`else
    logic             unused_tmo;
    assign unused_tmo = ^timeout_cycles;
`endif

    assign trig_edge = trig & ~trig_q;
    assign last_beat = (rd == len - ONE);

    capture_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (din),
        .raddr (rd[AW-1:0]),
        .rdata (buf_rdata)
    );

    // Next-state, pointer updates and buffer write strobe.
    always_comb begin
        state_d   = state;
        len_d     = len;
        wr_d      = wr;
        rd_d      = rd;
        buf_we    = 1'b0;
        buf_waddr = '0;
`ifdef TRIG_CAPTURE_TIMEOUT_EN
        tmo_lat_d = tmo_lat;
        tcnt_d    = tcnt;
        tpulse_d  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (arm) begin
                    if (cap_len == '0 || cap_len > LMAX) begin
                        len_d = LMAX;
                    end else begin
                        len_d = cap_len;
                    end
                    wr_d    = '0;
                    rd_d    = '0;
                    state_d = ARMED;
`ifdef TRIG_CAPTURE_TIMEOUT_EN
                    tmo_lat_d = timeout_cycles;
                    tcnt_d    = '0;
`endif
                end
            end
            ARMED: begin
                if (trig_edge) begin
                    buf_we  = 1'b1;
                    wr_d    = ONE;
                    state_d = (len == ONE) ? READOUT : CAPTURE;
                end
`ifdef TRIG_CAPTURE_TIMEOUT_EN
                else begin
                    tcnt_d = tcnt + TMO_W'(1);
                    if (tmo_lat != '0 && tcnt_d == tmo_lat) begin
                        state_d  = IDLE;
                        tpulse_d = 1'b1;
                    end
                end
`endif
            end
            CAPTURE: begin
                buf_we    = 1'b1;
                buf_waddr = wr[AW-1:0];
                wr_d      = wr + ONE;
                if (wr == len - ONE) begin
                    state_d = READOUT;
                end
            end
            READOUT: begin
                if (dout_ready) begin
                    rd_d = rd + ONE;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            buf_we  = 1'b0;
`ifdef TRIG_CAPTURE_TIMEOUT_EN
            tpulse_d = 1'b0;
`endif
        end
    end

    // State, trigger history, pointers and latched burst length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            trig_q <= 1'b0;
            len    <= '0;
            wr     <= '0;
            rd     <= '0;
        end else begin
            state  <= state_d;
            trig_q <= trig;
            len    <= len_d;
            wr     <= wr_d;
            rd     <= rd_d;
        end
    end

`ifdef TRIG_CAPTURE_TIMEOUT_EN
    // ARMED wait counter and registered one-cycle expiry pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_lat <= '0;
            tcnt    <= '0;
            tpulse  <= 1'b0;
        end else begin
            tmo_lat <= tmo_lat_d;
            tcnt    <= tcnt_d;
            tpulse  <= tpulse_d;
        end
    end

    assign timeout = tpulse;
`else
    assign timeout = 1'b0;
`endif

    assign dout_valid = (state == READOUT);
    assign dout       = dout_valid ? buf_rdata : '0;
    assign dout_last  = dout_valid & last_beat;
    assign armed      = (state == ARMED);
    assign busy       = (state != IDLE);

endmodule
